// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: RV opcodes, immediate formats
// and small index helpers used by the stage and its register file.
package id_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_IMM, LOAD, JALR: fmt = IMM_I;
            STORE:              fmt = IMM_S;
            BRANCH:             fmt = IMM_B;
            LUI, AUIPC:         fmt = IMM_U;
            JAL:                fmt = IMM_J;
            default:            fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // Index fields are always 5 bits wide, even when fewer registers exist.
    function automatic logic idx_in_range(input logic [4:0] idx, input logic [5:0] nregs);
        return {1'b0, idx} < nregs;
    endfunction

endpackage

// File: rtl/id_stage_p_if.sv
// Bus between the IF/ID register, the WB port and the ID/EX register of
// id_stage_p. The stage itself uses the slave side.
interface id_stage_p_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PC_ID;
    logic [31:0]     INSTRUCTION_ID;
    logic            VALID_ID;
    logic            FLUSH;
    logic            RegWrite_WB;
    logic [4:0]      RD_WB;
    logic [XLEN-1:0] ALU_DATA_WB;

    logic            STALL;
    logic            VALID_EX;
    logic [XLEN-1:0] PC_EX;
    logic [XLEN-1:0] IMM_EX;
    logic [XLEN-1:0] REG_DATA1_EX;
    logic [XLEN-1:0] REG_DATA2_EX;
    logic [6:0]      OPCODE_EX;
    logic [2:0]      FUNCT3_EX;
    logic [6:0]      FUNCT7_EX;
    logic [4:0]      RD_EX;
    logic [4:0]      RS1_EX;
    logic [4:0]      RS2_EX;
    logic            ILLEGAL_EX;

    modport master (
        output PC_ID, INSTRUCTION_ID, VALID_ID, FLUSH, RegWrite_WB, RD_WB, ALU_DATA_WB,
        input  STALL, VALID_EX, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
               OPCODE_EX, FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX, ILLEGAL_EX
    );

    modport slave (
        input  PC_ID, INSTRUCTION_ID, VALID_ID, FLUSH, RegWrite_WB, RD_WB, ALU_DATA_WB,
        output STALL, VALID_EX, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX,
               OPCODE_EX, FUNCT3_EX, FUNCT7_EX, RD_EX, RS1_EX, RS2_EX, ILLEGAL_EX
    );

endinterface

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// Optional ID_BYPASS_EN adds a WB-to-ID write-through mux on both read ports.
module id_regfile
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0 && idx_in_range(waddr, NREGS_W)) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    // Out-of-range indices read as zero; the stage flags them as illegal.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0 && idx_in_range(raddr1, NREGS_W)) begin
            rdata1 = regs[raddr1[AW-1:0]];
        end
`ifdef ID_BYPASS_EN
        if (we && waddr != 5'd0 && waddr == raddr1) begin
            rdata1 = wdata;
        end
`endif
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0 && idx_in_range(raddr2, NREGS_W)) begin
            rdata2 = regs[raddr2[AW-1:0]];
        end
`ifdef ID_BYPASS_EN
        if (we && waddr != 5'd0 && waddr == raddr2) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/id_stage_p.sv
// RISC-V decode stage: register file, immediate generation, load-use hazard
// detection and the ID/EX register. ID_BYPASS_EN selects WB-to-ID bypass.
module id_stage_p
    import id_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    id_stage_p_if.slave bus
);

    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_used;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            load_use;
    logic            wb_conflict;
    logic            haz;
    logic            stall;

    assign instr  = bus.INSTRUCTION_ID;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign rs1_used = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
    assign rs2_used = (opcode == OP || opcode == STORE || opcode == BRANCH);
    assign rd_used  = !(opcode == STORE || opcode == BRANCH);

    always_comb begin
        case (imm_fmt_of(opcode))
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    assign illegal = (rs1_used && !idx_in_range(rs1, NREGS_W))
                  || (rs2_used && !idx_in_range(rs2, NREGS_W))
                  || (rd_used  && !idx_in_range(rd,  NREGS_W));

    id_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (bus.RegWrite_WB),
        .waddr  (bus.RD_WB),
        .wdata  (bus.ALU_DATA_WB),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    assign load_use = bus.VALID_EX && bus.OPCODE_EX == LOAD && bus.RD_EX != 5'd0
                   && bus.VALID_ID
                   && ((rs1_used && bus.RD_EX == rs1) || (rs2_used && bus.RD_EX == rs2));

    // Without the bypass, a same-cycle WB write to a source waits one cycle
    // so the register file read sees the new value.
`ifdef ID_BYPASS_EN
    assign wb_conflict = 1'b0;
`else
    assign wb_conflict = bus.VALID_ID && bus.RegWrite_WB && bus.RD_WB != 5'd0
                      && ((rs1_used && bus.RD_WB == rs1) || (rs2_used && bus.RD_WB == rs2));
`endif

    assign haz       = load_use || wb_conflict;
    assign stall     = haz && !bus.FLUSH;
    assign bus.STALL = stall;

    // Reset, flush and stall all leave a zeroed bubble in ID/EX.
    always_ff @(posedge clk) begin
        if (reset || bus.FLUSH || stall) begin
            bus.VALID_EX     <= 1'b0;
            bus.PC_EX        <= '0;
            bus.IMM_EX       <= '0;
            bus.REG_DATA1_EX <= '0;
            bus.REG_DATA2_EX <= '0;
            bus.OPCODE_EX    <= '0;
            bus.FUNCT3_EX    <= '0;
            bus.FUNCT7_EX    <= '0;
            bus.RD_EX        <= '0;
            bus.RS1_EX       <= '0;
            bus.RS2_EX       <= '0;
            bus.ILLEGAL_EX   <= 1'b0;
        end else begin
            bus.VALID_EX     <= bus.VALID_ID;
            bus.PC_EX        <= bus.PC_ID;
            bus.IMM_EX       <= imm;
            bus.REG_DATA1_EX <= rdata1;
            bus.REG_DATA2_EX <= rdata2;
            bus.OPCODE_EX    <= opcode;
            bus.FUNCT3_EX    <= funct3;
            bus.FUNCT7_EX    <= funct7;
            bus.RD_EX        <= rd;
            bus.RS1_EX       <= rs1;
            bus.RS2_EX       <= rs2;
            bus.ILLEGAL_EX   <= illegal;
        end
    end

endmodule

// File: tb/tb_id_stage_p.sv
// Randomised self-checking bench for id_stage_p (XLEN=64, NREGS=16) against
// an instruction-level reference model, plus directed literal scenarios.
module tb_id_stage_p;
    import id_pkg::*;

    localparam int XL = 64;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    id_stage_p_if #(.XLEN(XL)) bus ();

    id_stage_p #(
        .XLEN  (XL),
        .NREGS (NR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic        rd1_known;
        logic        rd2_known;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } ex_t;

    logic [63:0] m_rf [32];
    ex_t         m_ex;
    logic        exp_stall;
    logic        seen_stall;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [6:0]  ops [11] = '{LOAD, LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, 7'h0F};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_range(input logic [4:0] r);
        return int'(r) < NR;
    endfunction

    // Immediate value computed as a weighted sum of instruction bits.
    function automatic logic [63:0] model_imm(input logic [31:0] ins);
        longint sgn = ins[31] ? 1 : 0;
        longint v;
        case (ins[6:0])
            LOAD, OP_IMM, JALR: v = longint'(ins[30:20]) - sgn * 2048;
            STORE:  v = longint'({ins[30:25], ins[11:7]}) - sgn * 2048;
            BRANCH: v = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32
                      + longint'(ins[7]) * 2048 - sgn * 4096;
            LUI, AUIPC: v = longint'(ins[30:12]) * 4096 - sgn * (longint'(1) << 31);
            JAL:    v = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
                      + longint'(ins[19:12]) * 4096 - sgn * (longint'(1) << 20);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP || op == STORE || op == BRANCH;
    endfunction

    function automatic logic uses_rd(input logic [6:0] op);
        return !(op == STORE || op == BRANCH);
    endfunction

    function automatic logic id_reads(input logic [4:0] r);
        logic [31:0] ins = bus.INSTRUCTION_ID;
        return bus.VALID_ID && ((uses_rs1(ins[6:0]) && ins[19:15] == r)
                             || (uses_rs2(ins[6:0]) && ins[24:20] == r));
    endfunction

    function automatic logic model_stall();
        logic h;
        h = m_ex.valid && m_ex.opcode == LOAD && m_ex.rd != 0 && id_reads(m_ex.rd);
`ifndef ID_BYPASS_EN
        h = h || (bus.RegWrite_WB && bus.RD_WB != 0 && id_reads(bus.RD_WB));
`endif
        return h && !bus.FLUSH;
    endfunction

    task automatic model_read(input logic [4:0] r, output logic [63:0] val, output logic known);
        val   = '0;
        known = 1'b1;
        if (r == 0) val = '0;
        else if (in_range(r)) val = m_rf[r];
        else known = 1'b0;
`ifdef ID_BYPASS_EN
        if (bus.RegWrite_WB && bus.RD_WB != 0 && bus.RD_WB == r) begin
            val   = bus.ALU_DATA_WB;
            known = 1'b1;
        end
`endif
    endtask

    task automatic model_clear();
        m_ex = '{default: '0};
    endtask

    task automatic model_step();
        logic [31:0] ins = bus.INSTRUCTION_ID;
        ex_t nx;
        nx = '{default: '0};
        if (!(reset || bus.FLUSH || exp_stall)) begin
            nx.valid   = bus.VALID_ID;
            nx.pc      = bus.PC_ID;
            nx.imm     = model_imm(ins);
            nx.opcode  = ins[6:0];
            nx.rd      = ins[11:7];
            nx.f3      = ins[14:12];
            nx.rs1     = ins[19:15];
            nx.rs2     = ins[24:20];
            nx.f7      = ins[31:25];
            nx.illegal = (uses_rs1(nx.opcode) && !in_range(nx.rs1))
                      || (uses_rs2(nx.opcode) && !in_range(nx.rs2))
                      || (uses_rd(nx.opcode) && !in_range(nx.rd));
            model_read(nx.rs1, nx.rd1, nx.rd1_known);
            model_read(nx.rs2, nx.rd2, nx.rd2_known);
        end else begin
            nx.rd1_known = 1'b1;
            nx.rd2_known = 1'b1;
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
        end else if (bus.RegWrite_WB && bus.RD_WB != 0 && in_range(bus.RD_WB)) begin
            m_rf[bus.RD_WB] = bus.ALU_DATA_WB;
        end
        m_ex = nx;
    endtask

    task automatic checkOutput();
        check("VALID_EX", 64'(bus.VALID_EX), 64'(m_ex.valid));
        check("PC_EX", bus.PC_EX, m_ex.pc);
        check("IMM_EX", bus.IMM_EX, m_ex.imm);
        if (m_ex.rd1_known) check("REG_DATA1_EX", bus.REG_DATA1_EX, m_ex.rd1);
        if (m_ex.rd2_known) check("REG_DATA2_EX", bus.REG_DATA2_EX, m_ex.rd2);
        check("OPCODE_EX", 64'(bus.OPCODE_EX), 64'(m_ex.opcode));
        check("FUNCT3_EX", 64'(bus.FUNCT3_EX), 64'(m_ex.f3));
        check("FUNCT7_EX", 64'(bus.FUNCT7_EX), 64'(m_ex.f7));
        check("RD_EX", 64'(bus.RD_EX), 64'(m_ex.rd));
        check("RS1_EX", 64'(bus.RS1_EX), 64'(m_ex.rs1));
        check("RS2_EX", 64'(bus.RS2_EX), 64'(m_ex.rs2));
        check("ILLEGAL_EX", 64'(bus.ILLEGAL_EX), 64'(m_ex.illegal));
    endtask

    // Inputs are already applied; compare STALL, advance the model, compare EX.
    task automatic run_cycle();
        #2;
        exp_stall  = model_stall();
        seen_stall = bus.STALL;
        check("STALL", 64'(bus.STALL), 64'(exp_stall));
        model_step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic set_id(input logic [31:0] ins, input logic v);
        bus.INSTRUCTION_ID = ins;
        bus.VALID_ID       = v;
        bus.PC_ID          = {$urandom, $urandom};
    endtask

    task automatic set_wb(input logic we, input logic [4:0] r, input logic [63:0] d);
        bus.RegWrite_WB = we;
        bus.RD_WB       = r;
        bus.ALU_DATA_WB = d;
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // While the stage stalls, IF holds the same instruction in ID.
    task automatic applyStimulus();
        logic [31:0] ins;
        if (!exp_stall) begin
            ins        = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 10)];
            ins[11:7]  = pick_reg();
            ins[19:15] = pick_reg();
            ins[24:20] = pick_reg();
            set_id(ins, $urandom_range(0, 7) != 0);
        end
        bus.FLUSH = ($urandom_range(0, 9) == 0);
        reset     = ($urandom_range(0, 49) == 0);
        set_wb(1'($urandom), pick_reg(), {$urandom, $urandom});
    endtask

    initial begin
        exp_stall  = 1'b0;
        seen_stall = 1'b0;
        reset      = 1'b1;
        bus.FLUSH  = 1'b0;
        set_id(32'h0000_0013, 1'b0);
        set_wb(1'b0, 5'd0, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        model_clear();
        checkOutput();
        check("reset_STALL", 64'(bus.STALL), 64'd0);
        check("reset_VALID_EX", 64'(bus.VALID_EX), 64'd0);
        check("reset_ILLEGAL_EX", 64'(bus.ILLEGAL_EX), 64'd0);
        check("reset_IMM_EX", bus.IMM_EX, 64'd0);
        reset = 1'b0;

        // addi x1,x0,5
        set_id(32'h0050_0093, 1'b1);
        run_cycle();
        check("addi_stall", 64'(seen_stall), 64'd0);
        check("addi_valid", 64'(bus.VALID_EX), 64'd1);
        check("addi_imm", bus.IMM_EX, 64'd5);
        check("addi_rd", 64'(bus.RD_EX), 64'd1);

        // add x4,x3,x0 while WB writes x3
        set_id(32'h0001_8233, 1'b1);
        set_wb(1'b1, 5'd3, 64'h0000_0000_DEAD_BEEF);
        run_cycle();
`ifdef ID_BYPASS_EN
        check("wb_bypass_stall", 64'(seen_stall), 64'd0);
        check("wb_bypass_data", bus.REG_DATA1_EX, 64'h0000_0000_DEAD_BEEF);
        set_wb(1'b0, 5'd0, 64'd0);
`else
        check("wb_conflict_stall", 64'(seen_stall), 64'd1);
        check("wb_conflict_bubble", 64'(bus.VALID_EX), 64'd0);
        set_wb(1'b0, 5'd0, 64'd0);
        run_cycle();
        check("wb_conflict_release", 64'(seen_stall), 64'd0);
        check("wb_conflict_data", bus.REG_DATA1_EX, 64'h0000_0000_DEAD_BEEF);
`endif

        // lw x5,0(x2) then add x6,x5,x1
        set_id(32'h0001_2283, 1'b1);
        run_cycle();
        set_id(32'h0012_8333, 1'b1);
        run_cycle();
        check("lu_stall", 64'(seen_stall), 64'd1);
        check("lu_bubble", 64'(bus.VALID_EX), 64'd0);
        run_cycle();
        check("lu_release", 64'(seen_stall), 64'd0);
        check("lu_add_valid", 64'(bus.VALID_EX), 64'd1);
        check("lu_add_rd", 64'(bus.RD_EX), 64'd6);

        // load-use hazard coinciding with FLUSH
        set_id(32'h0001_2283, 1'b1);
        run_cycle();
        set_id(32'h0012_8333, 1'b1);
        bus.FLUSH = 1'b1;
        run_cycle();
        check("flush_stall", 64'(seen_stall), 64'd0);
        check("flush_valid", 64'(bus.VALID_EX), 64'd0);
        bus.FLUSH = 1'b0;

        // beq x0,x0,-4096
        set_id(32'h8000_0063, 1'b1);
        run_cycle();
        check("branch_imm", bus.IMM_EX, 64'hFFFF_FFFF_FFFF_F000);

        // add x17,x1,x2
        set_id(32'h0020_88B3, 1'b1);
        run_cycle();
        check("illegal_rd17", 64'(bus.ILLEGAL_EX), 64'd1);

        set_id(32'h0020_88B3, 1'b0);
        set_wb(1'b1, 5'd1, 64'h11);
        run_cycle();
        set_wb(1'b1, 5'd17, 64'hBAD);
        run_cycle();
        set_wb(1'b1, 5'd0, 64'hFFFF);
        run_cycle();
        set_wb(1'b0, 5'd0, 64'd0);
        // add x7,x1,x0
        set_id(32'h0000_83B3, 1'b1);
        run_cycle();
        check("x17_write_ignored", bus.REG_DATA1_EX, 64'h11);
        check("x0_stays_zero", bus.REG_DATA2_EX, 64'd0);

        // reset asserted while a load-use stall is pending
        set_id(32'h0001_2283, 1'b1);
        run_cycle();
        set_id(32'h0012_8333, 1'b1);
        reset = 1'b1;
        run_cycle();
        check("rst_mid_stall", 64'(seen_stall), 64'd1);
        check("rst_mid_valid", 64'(bus.VALID_EX), 64'd0);
        reset = 1'b0;
        run_cycle();
        check("rst_stall_drop", 64'(seen_stall), 64'd0);

        for (int c = 0; c < 800; c++) begin
            applyStimulus();
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
